// File: rtl/ramp_pwm_generator.sv
// PWM ramp source for the ramp ADC: steps an 8-bit duty code every SETTLE_PERIODS
// PWM periods, as a sawtooth or triangle sweep, and flags step and sweep boundaries.
module ramp_pwm_generator #(
   parameter int unsigned SETTLE_PERIODS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       ramp_mode,
   output logic       pwm_out,
   output logic [7:0] duty_cycle,
   output logic       step_strobe,
   output logic       sweep_done
);

   localparam int unsigned SETTLE_W = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_PERIODS - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);

   logic [7:0]          pwm_cnt;
   logic [SETTLE_W-1:0] settle_cnt;
   logic                dir;
   logic                mode_q;

   logic                period_end;
   logic                settle_done;
   logic                step_now;
   logic [7:0]          duty_next;
   logic                dir_next;
   logic                sweep_next;

   assign period_end  = enable & (pwm_cnt == 8'hFF);
   assign settle_done = (settle_cnt == SETTLE_LAST);
   assign step_now    = period_end & settle_done;

   // Next ramp code; only committed at a step, so it can be computed every cycle.
   always_comb begin
      duty_next  = duty_cycle + 8'd1;
      dir_next   = dir;
      sweep_next = 1'b0;
      if (!mode_q) begin
         sweep_next = (duty_cycle == 8'hFF);
      end else if (dir) begin
         if (duty_cycle == 8'hFE) begin
            dir_next = 1'b0;
         end
      end else begin
         duty_next = duty_cycle - 8'd1;
         if (duty_cycle == 8'h01) begin
            dir_next   = 1'b1;
            sweep_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt     <= 8'd0;
         settle_cnt  <= '0;
         duty_cycle  <= 8'd0;
         pwm_out     <= 1'b0;
         step_strobe <= 1'b0;
         sweep_done  <= 1'b0;
         dir         <= 1'b1;
         mode_q      <= ramp_mode;
      end else if (!enable) begin
         pwm_out     <= 1'b0;
         step_strobe <= 1'b0;
         sweep_done  <= 1'b0;
      end else begin
         pwm_out     <= (pwm_cnt < duty_cycle);
         pwm_cnt     <= pwm_cnt + 8'd1;
         step_strobe <= step_now;
         sweep_done  <= step_now & sweep_next;
         if (period_end) begin
            if (settle_done) begin
               settle_cnt <= '0;
               duty_cycle <= duty_next;
               // Mode changes are only accepted at duty 0, so a sweep is never cut short.
               if (sweep_next) begin
                  dir    <= 1'b1;
                  mode_q <= ramp_mode;
               end else begin
                  dir    <= dir_next;
               end
            end else begin
               settle_cnt <= settle_cnt + SETTLE_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_ramp_pwm_generator.sv
// Self-checking bench: four ramp_pwm_generator instances run side by side against a
// step-index reference model, plus targeted boundary checks.
module tb_ramp_pwm_generator;

   localparam int END_EDGES = 70000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a = 1'b1, enable_a = 1'b1, ramp_mode_a = 1'b0;
   logic       reset_b = 1'b1, enable_b = 1'b1, ramp_mode_b = 1'b0;
   logic       reset_c = 1'b1, enable_c = 1'b1, ramp_mode_c = 1'b1;
   logic       reset_d = 1'b1, enable_d = 1'b1, ramp_mode_d = 1'b0;
   logic       pwm_out_a, step_a, sweep_a;
   logic       pwm_out_b, step_b, sweep_b;
   logic       pwm_out_c, step_c, sweep_c;
   logic       pwm_out_d, step_d, sweep_d;
   logic [7:0] duty_a, duty_b, duty_c, duty_d;

   ramp_pwm_generator #(.SETTLE_PERIODS(4)) dut_a (
      .clk(clk), .reset(reset_a), .enable(enable_a), .ramp_mode(ramp_mode_a),
      .pwm_out(pwm_out_a), .duty_cycle(duty_a), .step_strobe(step_a), .sweep_done(sweep_a));
   ramp_pwm_generator #(.SETTLE_PERIODS(1)) dut_b (
      .clk(clk), .reset(reset_b), .enable(enable_b), .ramp_mode(ramp_mode_b),
      .pwm_out(pwm_out_b), .duty_cycle(duty_b), .step_strobe(step_b), .sweep_done(sweep_b));
   ramp_pwm_generator #(.SETTLE_PERIODS(1)) dut_c (
      .clk(clk), .reset(reset_c), .enable(enable_c), .ramp_mode(ramp_mode_c),
      .pwm_out(pwm_out_c), .duty_cycle(duty_c), .step_strobe(step_c), .sweep_done(sweep_c));
   ramp_pwm_generator #(.SETTLE_PERIODS(1)) dut_d (
      .clk(clk), .reset(reset_d), .enable(enable_d), .ramp_mode(ramp_mode_d),
      .pwm_out(pwm_out_d), .duty_cycle(duty_d), .step_strobe(step_d), .sweep_done(sweep_d));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rel      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the ramp is a function of the step index within the current sweep.
   typedef struct {
      int phase;
      int periods;
      int step;
      bit mode;
      int code;
      bit pwm;
      bit stb;
      bit swp;
   } model_t;

   function automatic int code_of(bit mode, int step);
      if (!mode) return step;
      return (step <= 255) ? step : 510 - step;
   endfunction

   function automatic model_t model_next(model_t m, bit rst, bit en, bit rmode, int sp);
      model_t n;
      n = m;
      n.pwm = 1'b0;
      n.stb = 1'b0;
      n.swp = 1'b0;
      if (rst) begin
         n.phase   = 0;
         n.periods = 0;
         n.step    = 0;
         n.mode    = rmode;
         n.code    = 0;
      end else if (en) begin
         n.pwm   = (m.phase < m.code);
         n.phase = (m.phase + 1) % 256;
         if (m.phase == 255) begin
            n.periods = m.periods + 1;
            if (n.periods == sp) begin
               n.periods = 0;
               n.stb     = 1'b1;
               n.step    = m.step + 1;
               if (n.step == (m.mode ? 510 : 256)) begin
                  n.step = 0;
                  n.swp  = 1'b1;
                  n.mode = rmode;
               end
               n.code = code_of(n.mode, n.step);
            end
         end
      end
      return n;
   endfunction

   function automatic logic [31:0] pk(logic p, logic [7:0] d, logic s, logic w);
      return {21'd0, p, d, s, w};
   endfunction

   model_t m_a, m_b, m_c, m_d;
   bit va = 1'b0, vb = 1'b0, vc = 1'b0, vd = 1'b0;

   always @(posedge clk) begin
      cyc++;
      m_a = model_next(m_a, reset_a, enable_a, ramp_mode_a, 4);
      m_b = model_next(m_b, reset_b, enable_b, ramp_mode_b, 1);
      m_c = model_next(m_c, reset_c, enable_c, ramp_mode_c, 1);
      m_d = model_next(m_d, reset_d, enable_d, ramp_mode_d, 1);
      if (reset_a) va = 1'b1;
      if (reset_b) vb = 1'b1;
      if (reset_c) vc = 1'b1;
      if (reset_d) vd = 1'b1;
   end

   always @(negedge clk) begin
      if (va) begin
         check("a_out", pk(pwm_out_a, duty_a, step_a, sweep_a),
               pk(m_a.pwm, 8'(m_a.code), m_a.stb, m_a.swp));
         check("a_int", {22'd0, dut_a.pwm_cnt, dut_a.settle_cnt},
               {22'd0, 8'(m_a.phase), 2'(m_a.periods)});
      end
      if (vb) begin
         check("b_out", pk(pwm_out_b, duty_b, step_b, sweep_b),
               pk(m_b.pwm, 8'(m_b.code), m_b.stb, m_b.swp));
         check("b_cnt", {24'd0, dut_b.pwm_cnt}, 32'(m_b.phase));
      end
      if (vc) begin
         check("c_out", pk(pwm_out_c, duty_c, step_c, sweep_c),
               pk(m_c.pwm, 8'(m_c.code), m_c.stb, m_c.swp));
         check("c_cnt", {24'd0, dut_c.pwm_cnt}, 32'(m_c.phase));
      end
      if (vd) begin
         check("d_out", pk(pwm_out_d, duty_d, step_d, sweep_d),
               pk(m_d.pwm, 8'(m_d.code), m_d.stb, m_d.swp));
         check("d_cnt", {24'd0, dut_d.pwm_cnt}, 32'(m_d.phase));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic int el();
      return cyc - rel;
   endfunction

   // SETTLE_PERIODS=4: first step timing, enable pause at pwm_cnt 37, random pauses.
   task automatic run_a();
      int highs;
      int exp_settle;
      while (!step_a && el() < 1100) tick();
      check("a_first_step_edge", 32'(el()), 32'd1024);
      check("a_first_step_duty", {24'd0, duty_a}, 32'd1);
      while (m_a.phase != 37 && el() < 1400) tick();
      check("a_pause_phase", {24'd0, dut_a.pwm_cnt}, 32'd37);
      exp_settle = m_a.periods;
      enable_a = 1'b0;
      highs = 0;
      repeat (100) begin
         tick();
         highs += int'(pwm_out_a);
      end
      check("a_pause_pwm_highs", 32'(highs), 32'd0);
      check("a_pause_duty", {24'd0, duty_a}, 32'd1);
      check("a_pause_settle", {30'd0, dut_a.settle_cnt}, 32'(exp_settle));
      check("a_pause_cnt", {24'd0, dut_a.pwm_cnt}, 32'd37);
      enable_a = 1'b1;
      while (!step_a && el() < 2300) tick();
      check("a_second_step_edge", 32'(el()), 32'd2148);
      while (el() < END_EDGES) begin
         enable_a = ($urandom_range(0, 7) != 0);
         repeat ($urandom_range(1, 40)) tick();
      end
      enable_a = 1'b1;
   endtask

   // SETTLE_PERIODS=1 sawtooth: PWM windows, full sweep wrap, switch to triangle at 0.
   task automatic run_b();
      int dl[4];
      int highs[4];
      int sweeps;
      int e;
      dl = '{0, 1, 128, 255};
      highs = '{0, 0, 0, 0};
      sweeps = 0;
      while (el() < 65536) begin
         if (el() < 60000 && $urandom_range(0, 499) == 0) ramp_mode_b = ~ramp_mode_b;
         if (el() >= 62000) ramp_mode_b = 1'b1;
         tick();
         e = el();
         if (e < 65536) sweeps += int'(sweep_b);
         for (int i = 0; i < 4; i++)
            if (e > 256 * dl[i] && e <= 256 * dl[i] + 256) highs[i] += int'(pwm_out_b);
         if (e == 256 * 128) check("b_duty_128", {24'd0, duty_b}, 32'd128);
      end
      for (int i = 0; i < 4; i++) check($sformatf("b_pwm_window_%0d", dl[i]), 32'(highs[i]), 32'(dl[i]));
      check("b_sweeps_before_wrap", 32'(sweeps), 32'd0);
      check("b_wrap", pk(pwm_out_b, duty_b, step_b, sweep_b), pk(1'b0, 8'd0, 1'b1, 1'b1));
      repeat (256) tick();
      check("b_tri_after_switch", {24'd0, duty_b}, 32'd1);
      while (el() < END_EDGES) begin
         if ($urandom_range(0, 299) == 0) ramp_mode_b = ~ramp_mode_b;
         tick();
      end
   endtask

   // SETTLE_PERIODS=1 triangle with ramp_mode toggled mid-sweep (must be ignored).
   task automatic run_c();
      int e;
      while (el() < END_EDGES) begin
         if (el() > 1000 && $urandom_range(0, 299) == 0) ramp_mode_c = ~ramp_mode_c;
         tick();
         e = el();
         if (e == 256)   check("c_first_up", {24'd0, duty_c}, 32'd1);
         if (e == 65280) check("c_peak", pk(1'b0, duty_c, step_c, sweep_c), pk(1'b0, 8'd255, 1'b1, 1'b0));
         if (e == 65535) check("c_peak_hold", {24'd0, duty_c}, 32'd255);
         if (e == 65536) check("c_turn", pk(1'b0, duty_c, step_c, sweep_c), pk(1'b0, 8'd254, 1'b1, 1'b0));
      end
   endtask

   // SETTLE_PERIODS=1 with random enable gaps, reset mid-sweep at duty 77.
   task automatic run_d();
      while (duty_d != 8'd77 && el() < 60000) begin
         enable_d = ($urandom_range(0, 3) != 0);
         tick();
      end
      check("d_reach_77", {24'd0, duty_d}, 32'd77);
      reset_d = 1'b1;
      tick();
      reset_d = 1'b0;
      check("d_reset_outputs", pk(pwm_out_d, duty_d, step_d, sweep_d), pk(1'b0, 8'd0, 1'b0, 1'b0));
      check("d_reset_cnt", {24'd0, dut_d.pwm_cnt}, 32'd0);
      enable_d = 1'b1;
      repeat (256) tick();
      check("d_restart_step", pk(1'b0, duty_d, step_d, sweep_d), pk(1'b0, 8'd1, 1'b1, 1'b0));
      while (el() < END_EDGES) begin
         enable_d = ($urandom_range(0, 4) != 0);
         repeat ($urandom_range(1, 30)) tick();
      end
      enable_d = 1'b1;
   endtask

   initial begin
      repeat (3) tick();
      check("a_in_reset", pk(pwm_out_a, duty_a, step_a, sweep_a), 32'd0);
      check("b_in_reset", pk(pwm_out_b, duty_b, step_b, sweep_b), 32'd0);
      check("c_in_reset", pk(pwm_out_c, duty_c, step_c, sweep_c), 32'd0);
      check("d_in_reset", pk(pwm_out_d, duty_d, step_d, sweep_d), 32'd0);
      reset_a = 1'b0;
      reset_b = 1'b0;
      reset_c = 1'b0;
      reset_d = 1'b0;
      rel = cyc;
      fork
         run_a();
         run_b();
         run_c();
         run_d();
      join
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/ramp_pwm_generator.md
# ramp_pwm_generator

Generates the 8-bit sawtooth (or triangle) reference ramp for the ramp-based ADC. It produces a PWM waveform whose duty steps by one code after a programmable number of PWM periods, so the external RC filter can settle at each step. It exports the current `duty_cycle` code to the downstream falling-edge capture stage, and reports step and sweep boundaries.

## Interface
Parameters:
- `SETTLE_PERIODS`, default 4: full PWM periods spent at each duty code before stepping. Legal range is 1..256.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-high. Clock is `clk`.
- `enable`, in, 1: run when high. When low, all counters freeze.
- `ramp_mode`, in, 1: 0 selects sawtooth, 1 selects triangle. Sampled only at reset and at sweep boundaries.
- `pwm_out`, out, 1: registered PWM output that drives the RC filter.
- `duty_cycle`, out, 8: current ramp code, consumed by the capture stage.
- `step_strobe`, out, 1: one-cycle pulse in the cycle after `duty_cycle` changes.
- `sweep_done`, out, 1: one-cycle pulse in the cycle after `duty_cycle` returns to 0.

## Operation
- Internal state:
  - `pwm_cnt[7:0]`: free-running period counter, 0..255. Period is 256 clocks.
  - `settle_cnt`: width $clog2(SETTLE_PERIODS), minimum 1 bit.
  - `dir`: direction, 1 = up.
  - `mode_q`: latched copy of `ramp_mode`.
- Reset values:
  - `pwm_cnt`, `settle_cnt`, `duty_cycle`, `pwm_out`, `step_strobe`, `sweep_done` all 0.
  - `dir` = 1.
  - `mode_q` <= `ramp_mode`.
- Each enabled cycle:
  - `pwm_out` <= (`pwm_cnt` < `duty_cycle`), using pre-edge values. Unsigned compare.
  - `pwm_cnt` increments and wraps from 255 to 0.
- Period end is `pwm_cnt` == 255 while enabled. At period end, if `settle_cnt` == SETTLE_PERIODS-1, then in the same edge:
  - `settle_cnt` is cleared, the duty is updated, and `step_strobe` is set.
  - Otherwise `settle_cnt` increments.
- Sawtooth duty update (`mode_q`=0): `duty_cycle` <= `duty_cycle`+1, with 8-bit wrap. On wrap 255→0, set `sweep_done`.
- Triangle duty update (`mode_q`=1):
  - While up: increment. When the new value is 255, clear `dir`.
  - While down: decrement. When the new value is 0, set `dir` and set `sweep_done`.
  - Codes 255 and 0 are each held for one step only; they are never repeated.
- At every update that sets `sweep_done`, `mode_q` <= `ramp_mode`, and `dir` is forced to 1.
  - This makes a mode switch take effect only at duty 0.
- Sweep length:
  - Sawtooth: 256 steps.
  - Triangle: 510 steps.
- `enable` low:
  - `pwm_cnt`, `settle_cnt`, `duty_cycle`, `dir` and `mode_q` hold.
  - `pwm_out` <= 0, and strobes are 0.
  - On re-enable, operation resumes from the held counts. Period phase is preserved, not restarted.
- Reset mid-operation: all state returns to its reset value on the next edge. No strobe is emitted for the reset transition.

## Timing
- `duty_cycle` changes only at the edge where `pwm_cnt` goes 255→0. The output is therefore glitch-free, with no partial periods.
- `pwm_out` lags `pwm_cnt` by one cycle.
  - Every 256-cycle window starting one cycle after a period start holds exactly `duty_cycle` high cycles.
  - Duty 0 gives a constant low output. Duty 255 gives 255/256 high.
- `step_strobe` and `sweep_done` are registered and high for exactly one cycle: the first cycle showing the new `duty_cycle`. When both fire, they are simultaneous.
- Step interval: 256×SETTLE_PERIODS enabled cycles.
- First step: after 256×SETTLE_PERIODS enabled cycles from reset release.

## Test plan
- Reset: hold `reset` for 3 cycles with `enable`=1 → all outputs 0 and `pwm_out` stays 0. Then release with SETTLE_PERIODS=4 → `duty_cycle`=0 until 1024 enabled cycles have elapsed; `duty_cycle`=1 and `step_strobe`=1 in cycle 1025 only.
- PWM accuracy, SETTLE_PERIODS=1: for duty 0, 1, 128 and 255, count `pwm_out` highs over the 256-cycle window aligned one cycle after the period start → exactly 0, 1, 128 and 255.
- Sawtooth wrap, SETTLE_PERIODS=1: run 65536 cycles → `duty_cycle` goes 255→0, with `sweep_done` and `step_strobe` both pulsed in that one cycle. No other `sweep_done` appears in the sweep.
- Triangle, SETTLE_PERIODS=1, `ramp_mode`=1: code sequence is …254, 255, 254…1, 0, 1. `sweep_done` is pulsed only when 0 is reached, after 510 steps. Toggle `ramp_mode` to 0 mid-sweep → no effect until duty reaches 0; sawtooth from then on.
- Enable pause: drop `enable` for 100 cycles at `pwm_cnt`=37 → `pwm_out` is 0 throughout, and `duty_cycle` and `settle_cnt` hold. After re-enable, the next step occurs exactly 100 cycles later than nominal.
- Reset mid-sweep: assert `reset` for 1 cycle at `duty_cycle`=77 → next cycle all state is 0, with no strobe. The ramp restarts from 0.
